// File: rtl/mfsk_dds_mod.sv
// M-ary FSK modulator built around one phase accumulator.
// A run-time FTW table holds 2^SYM_BITS tones. Symbols are accepted into a
// one-entry holding register and transmitted for SYM_SAMPLES DAC samples each.
// The tone switches at symbol boundaries with no phase reset, so the output
// phase stays continuous.
//
// Ports:
//   sys_clk_i    system clock, rising edge
//   sys_rst_i    asynchronous active-high reset
//   enable_i     run enable; low freezes sample timing and the datapath
//   ftw_we_i     FTW table write strobe
//   ftw_sel_i    FTW table write index
//   ftw_wdata_i  FTW write value
//   sym_valid_i  symbol offered
//   sym_data_i   symbol value (tone index)
//   sym_ready_o  holding register empty
//   busy_o       transmitting a symbol
//   rom_addr_o   external sine ROM address (top bits of the accumulator)
//   rom_data_i   sine ROM data, one cycle after rom_addr_o
//   da_clk_o     registered DAC sample clock
//   da_data_o    registered DAC sample
module mfsk_dds_mod #(
    parameter int unsigned PHASE_W     = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYM_BITS    = 1,
    parameter int unsigned SAMPLE_DIV  = 2,
    parameter int unsigned SYM_SAMPLES = 1000
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    input  logic                enable_i,
    input  logic                ftw_we_i,
    input  logic [SYM_BITS-1:0] ftw_sel_i,
    input  logic [PHASE_W-1:0]  ftw_wdata_i,
    input  logic                sym_valid_i,
    input  logic [SYM_BITS-1:0] sym_data_i,
    output logic                sym_ready_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   rom_addr_o,
    input  logic [DATA_W-1:0]   rom_data_i,
    output logic                da_clk_o,
    output logic [DATA_W-1:0]   da_data_o
);

    localparam int unsigned NumTones = 2 ** SYM_BITS;
    localparam int unsigned DivW     = $clog2(SAMPLE_DIV);
    localparam int unsigned SymCntW  = (SYM_SAMPLES > 1) ? $clog2(SYM_SAMPLES) : 1;

    localparam logic [DivW-1:0]    DivLast  = DivW'(SAMPLE_DIV - 1);
    localparam logic [DivW-1:0]    DivHalf  = DivW'(SAMPLE_DIV / 2);
    localparam logic [SymCntW-1:0] SymLast  = SymCntW'(SYM_SAMPLES - 1);
    localparam logic [DATA_W-1:0]  MidScale = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e state_q, state_d;

    logic [NumTones-1:0][PHASE_W-1:0] ftw_q;
    logic [PHASE_W-1:0]  acc_q, acc_d;
    logic [DivW-1:0]     div_cnt_q, div_cnt_d;
    logic [SymCntW-1:0]  sym_cnt_q, sym_cnt_d;
    logic                hold_valid_q, hold_valid_d;
    logic [SYM_BITS-1:0] hold_sym_q, hold_sym_d;
    logic [SYM_BITS-1:0] cur_sym_q, cur_sym_d;
    logic                was_send_q, was_send_d;
    logic                da_clk_q, da_clk_d;
    logic [DATA_W-1:0]   da_data_q, da_data_d;

    logic tick;
    logic load;

    assign tick = enable_i && (div_cnt_q == DivLast);
    // A held symbol starts on a tick when idle, or on the last sample of the current symbol.
    assign load = tick && hold_valid_q && ((state_q == StIdle) || (sym_cnt_q == SymLast));

    // FTW table: writes are independent of enable and state.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ftw_q <= '0;
        end else if (ftw_we_i) begin
            ftw_q[ftw_sel_i] <= ftw_wdata_i;
        end
    end

    // State register.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load) state_d = StSend;
            end
            StSend: begin
                if (tick && (sym_cnt_q == SymLast) && !hold_valid_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o      = (state_q == StSend);
        sym_ready_o = !hold_valid_q;
    end

    // Datapath next-state.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        acc_d        = acc_q;
        sym_cnt_d    = sym_cnt_q;
        cur_sym_d    = cur_sym_q;
        hold_valid_d = hold_valid_q;
        hold_sym_d   = hold_sym_q;
        was_send_d   = was_send_q;
        da_data_d    = da_data_q;

        if (enable_i) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
        end

        if (tick) begin
            // acc is one sample ahead of the DAC: only samples whose phase was
            // advanced during a SEND sample carry ROM data.
            da_data_d  = was_send_q ? rom_data_i : MidScale;
            was_send_d = (state_q == StSend);
        end

        if (tick && (state_q == StSend)) begin
            acc_d     = acc_q + ftw_q[cur_sym_q];
            sym_cnt_d = sym_cnt_q + SymCntW'(1);
        end

        // Consume takes priority; acceptance only happens while the holder is empty.
        if (load) begin
            cur_sym_d    = hold_sym_q;
            sym_cnt_d    = '0;
            hold_valid_d = 1'b0;
        end else if (sym_valid_i && !hold_valid_q) begin
            hold_sym_d   = sym_data_i;
            hold_valid_d = 1'b1;
        end

        // Registered DAC clock; forced low while disabled.
        da_clk_d = enable_i && (div_cnt_d >= DivHalf);
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            acc_q        <= '0;
            div_cnt_q    <= '0;
            sym_cnt_q    <= '0;
            cur_sym_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_sym_q   <= '0;
            was_send_q   <= 1'b0;
            da_clk_q     <= 1'b0;
            da_data_q    <= MidScale;
        end else begin
            acc_q        <= acc_d;
            div_cnt_q    <= div_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            cur_sym_q    <= cur_sym_d;
            hold_valid_q <= hold_valid_d;
            hold_sym_q   <= hold_sym_d;
            was_send_q   <= was_send_d;
            da_clk_q     <= da_clk_d;
            da_data_q    <= da_data_d;
        end
    end

    assign rom_addr_o = acc_q[PHASE_W-1 -: ADDR_W];
    assign da_clk_o   = da_clk_q;
    assign da_data_o  = da_data_q;

endmodule

// File: tb/tb_mfsk_dds_mod.sv
// Bench for mfsk_dds_mod (SAMPLE_DIV=2, SYM_SAMPLES=4). A sample-level model
// pushes the expected outputs each clock; the monitor pops and compares them.
module tb_mfsk_dds_mod;

    localparam int SDIV = 2;
    localparam int SYMS = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic        ftw_we;
    logic        ftw_sel;
    logic [31:0] ftw_wdata;
    logic        sym_valid;
    logic        sym_data;
    logic        sym_ready;
    logic        busy;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        da_clk;
    logic [7:0]  da_data;

    int n_checks = 0;
    int n_errors = 0;

    mfsk_dds_mod #(
        .PHASE_W    (32),
        .ADDR_W     (8),
        .DATA_W     (8),
        .SYM_BITS   (1),
        .SAMPLE_DIV (SDIV),
        .SYM_SAMPLES(SYMS)
    ) dut (
        .sys_clk_i  (sys_clk),
        .sys_rst_i  (sys_rst),
        .enable_i   (enable),
        .ftw_we_i   (ftw_we),
        .ftw_sel_i  (ftw_sel),
        .ftw_wdata_i(ftw_wdata),
        .sym_valid_i(sym_valid),
        .sym_data_i (sym_data),
        .sym_ready_o(sym_ready),
        .busy_o     (busy),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .da_clk_o   (da_clk),
        .da_data_o  (da_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Odd multiplier makes every address map to a distinct sample.
    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return a * 8'd7 + 8'h21;
    endfunction

    always @(posedge sys_clk) rom_data <= rom_fn(rom_addr);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       busy;
        logic       ready;
        logic       daclk;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_push;
    exp_t        e_pop;
    int          m_div;
    int          m_cnt;
    logic [31:0] m_acc;
    logic [31:0] m_ftw[2];
    logic        m_send;
    logic        m_cur;
    logic        m_hold_v;
    logic        m_hold_s;
    logic        m_was_send;
    logic [7:0]  m_da;
    logic        m_tick;
    logic        m_load;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_div = 0; m_cnt = 0; m_acc = '0; m_ftw[0] = '0; m_ftw[1] = '0;
            m_send = 1'b0; m_cur = 1'b0; m_hold_v = 1'b0; m_hold_s = 1'b0;
            m_was_send = 1'b0; m_da = 8'h80;
            exp_q.delete();
        end else begin
            m_tick = enable && (m_div == SDIV - 1);
            m_load = m_tick && m_hold_v && (!m_send || m_cnt == SYMS - 1);
            if (m_tick) begin
                m_da       = m_was_send ? rom_fn(m_acc[31:24]) : 8'h80;
                m_was_send = m_send;
                if (m_send) begin
                    m_acc = m_acc + m_ftw[m_cur];
                    if (m_cnt == SYMS - 1 && !m_hold_v) m_send = 1'b0;
                    else m_cnt++;
                end
            end
            if (m_load) begin
                m_cur = m_hold_s; m_cnt = 0; m_send = 1'b1; m_hold_v = 1'b0;
            end else if (sym_valid && !m_hold_v) begin
                m_hold_v = 1'b1; m_hold_s = sym_data;
            end
            if (ftw_we) m_ftw[ftw_sel] = ftw_wdata;
            if (enable) m_div = m_tick ? 0 : m_div + 1;
            e_push = '{addr: m_acc[31:24], data: m_da, busy: m_send, ready: !m_hold_v,
                       daclk: enable && (m_div >= SDIV / 2)};
            exp_q.push_back(e_push);
            #1;
            if (exp_q.size() != 0) begin
                e_pop = exp_q.pop_front();
                check_eq("rom_addr", 64'(rom_addr), 64'(e_pop.addr));
                check_eq("da_data", 64'(da_data), 64'(e_pop.data));
                check_eq("busy", 64'(busy), 64'(e_pop.busy));
                check_eq("sym_ready", 64'(sym_ready), 64'(e_pop.ready));
                check_eq("da_clk", 64'(da_clk), 64'(e_pop.daclk));
            end
        end
    end

    // ---------------- stimulus tasks (all start and end at a negedge) ----------------
    task automatic write_ftw(input logic sel, input logic [31:0] val);
        ftw_we = 1'b1; ftw_sel = sel; ftw_wdata = val;
        @(negedge sys_clk);
        ftw_we = 1'b0;
    endtask

    // Leaves sym_valid high so consecutive calls keep it asserted.
    task automatic send_sym(input logic s);
        int n;
        n = 0;
        sym_valid = 1'b1; sym_data = s;
        while (!sym_ready && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("accept_wait", 64'(n >= 400), 64'd0);
        @(negedge sys_clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        sym_valid = 1'b0;
        while ((m_send || m_hold_v) && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("idle_wait", 64'(n >= 2000), 64'd0);
        repeat (4 * SDIV) @(negedge sys_clk);
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_da_data"}, 64'(da_data), 64'h80);
        check_eq({tag, "_da_clk"}, 64'(da_clk), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_ready"}, 64'(sym_ready), 64'd1);
        check_eq({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
    endtask

    task automatic apply_reset(input string tag);
        #2 sys_rst = 1'b1;
        #1 reset_checks(tag);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1; enable = 1'b1; ftw_we = 1'b0; ftw_sel = 1'b0; ftw_wdata = '0;
        sym_valid = 1'b0; sym_data = 1'b0;
        #1 reset_checks("por");
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;

        // Single tone.
        write_ftw(1'b0, 32'h0100_0000);
        write_ftw(1'b1, 32'h0300_0000);
        send_sym(1'b0);
        wait_idle();
        check_eq("single_addr", 64'(rom_addr), 64'd4);
        check_eq("single_mid", 64'(da_data), 64'h80);

        // Back-to-back two tones from a fresh accumulator.
        @(negedge sys_clk);
        apply_reset("rst2");
        write_ftw(1'b0, 32'h0100_0000);
        write_ftw(1'b1, 32'h0300_0000);
        send_sym(1'b0);
        send_sym(1'b1);
        wait_idle();
        check_eq("b2b_addr", 64'(rom_addr), 64'd16);

        // Three symbols with sym_valid held.
        send_sym(1'b1);
        send_sym(1'b0);
        send_sym(1'b1);
        wait_idle();
        check_eq("hs3_addr", 64'(rom_addr), 64'd44);

        // enable low for 5 cycles mid-symbol.
        send_sym(1'b0);
        sym_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        enable = 1'b0;
        repeat (5) @(negedge sys_clk);
        check_eq("en_low_da_clk", 64'(da_clk), 64'd0);
        enable = 1'b1;
        wait_idle();
        check_eq("en_addr", 64'(rom_addr), 64'd48);

        // Rewrite the active tone mid-symbol.
        send_sym(1'b0);
        sym_valid = 1'b0;
        repeat (4) @(negedge sys_clk);
        write_ftw(1'b0, 32'h0200_0000);
        wait_idle();

        // Random tones, symbols and enable pauses.
        write_ftw(1'b0, $urandom);
        write_ftw(1'b1, $urandom);
        for (int i = 0; i < 8; i++) begin
            send_sym(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge sys_clk);
                enable = 1'b1;
            end
        end
        wait_idle();

        // Reset in the middle of a symbol with another one held.
        send_sym(1'b1);
        send_sym(1'b0);
        sym_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        apply_reset("midrst");
        repeat (10) @(negedge sys_clk);
        check_eq("post_rst_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
